// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and sizing helpers for the APB memory slave
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int WS_W = 4;

  function automatic int byte_off_w(input int data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 0;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - word memory with byte-enable write and registered read
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = idx_w(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset here so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB slave fronting a word memory with wait states and range errors
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam int                  OFF_W   = byte_off_w(DATA_WIDTH);
  localparam int                  IDX_W   = idx_w(DEPTH);
  localparam logic [WS_W-1:0]     WS_C    = WS_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  apb_state_e            state_q, state_d;
  logic [WS_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         strb_q, strb_d;
  logic                  err_q, err_d;
  logic                  rvalid_q, rvalid_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_err;
  logic                  ready;
  logic                  mem_we, mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign word_idx = paddr >> OFF_W;
  assign req_err  = {1'b0, word_idx} >= DEPTH_C;
  assign ready    = (state_q == ACCESS) && (cnt_q == WS_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
          idx_d   = IDX_W'(word_idx);
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = req_err;
          if (!pwrite) begin
            mem_re   = !req_err;
            rvalid_d = !req_err;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          if (cnt_q < WS_C) cnt_d = cnt_q + 1'b1;
          if (penable && ready) begin
            state_d = IDLE;
            mem_we  = write_q && !err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Reset must also drop a write that would commit on the same edge.
  apb_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk_i  (pclk),
    .we_i   (mem_we && presetn),
    .waddr_i(idx_q),
    .wdata_i(wdata_q),
    .wstrb_i(strb_q),
    .re_i   (mem_re),
    .raddr_i(IDX_W'(word_idx)),
    .rdata_o(mem_rdata)
  );

  assign prdata  = rvalid_q ? mem_rdata : '0;
  assign pready  = ready;
  assign pslverr = ready && err_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - randomized bench for two apb_mem_slave configurations against an array model
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel0 = 1'b0, psel1 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata0;
  logic [7:0]  prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m0 [16];
  logic [7:0]  m1 [32];

  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .pclk(clk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0)
  );

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(32), .WAIT_STATES(3)) u_dut1 (
    .pclk(clk), .presetn(presetn), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]), .pstrb(pstrb[0:0]), .prdata(prdata1),
    .pready(pready1), .pslverr(pslverr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 1) ? pready1 : pready0;
  endfunction

  function automatic logic serr(input int w);
    return (w == 1) ? pslverr1 : pslverr0;
  endfunction

  function automatic logic [31:0] prd(input int w);
    return (w == 1) ? {24'h0, prdata1} : prdata0;
  endfunction

  task automatic bus_idle();
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  // Leaves psel/penable asserted so a following call forms a back-to-back transfer.
  task automatic xfer(input int w, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output bit er,
                      output int lat, output bit bad);
    psel0 = (w == 0); psel1 = (w == 1);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    bad = 1'b0;
    lat = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 2;
    while (!rdy(w) && lat < 40) begin
      if (serr(w)) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rd = prd(w);
    er = serr(w);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input int w, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
    int          idx;
    bit          eerr, er, bad;
    int          lat;
    logic [31:0] erd, dd;
    logic [3:0]  ss;
    dd = d; ss = s;
    if (w == 0) begin
      idx = int'(a) / 4;
      eerr = (idx >= 16);
    end else begin
      idx = int'(a);
      eerr = (idx >= 32);
      dd = {24'h0, d[7:0]};
      ss = {3'b0, s[0]};
    end
    erd = '0;
    if (!eerr && !wr) erd = (w == 0) ? m0[idx] : {24'h0, m1[idx]};
    xfer(w, wr, a, dd, ss, rd, er, lat, bad);
    check(wr ? "wr_slverr" : "rd_slverr", {31'h0, er}, {31'h0, eerr});
    check("latency", lat, (w == 0) ? 2 : 5);
    check("slverr_while_wait", {31'h0, bad}, 32'h0);
    if (!wr) begin
      check("rdata", rd, erd);
      check("rdata_hold", prd(w), erd);
    end
    if (wr && !eerr) begin
      for (int b = 0; b < 4; b++) begin
        if (ss[b]) begin
          if (w == 0) m0[idx][8*b +: 8] = dd[8*b +: 8];
          else if (b == 0) m1[idx] = dd[7:0];
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          seen;
    int          w;
    logic [7:0]  a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_pready0", {31'h0, pready0}, 32'h0);
    check("rst_pslverr0", {31'h0, pslverr0}, 32'h0);
    check("rst_prdata1", {24'h0, prdata1}, 32'h0);
    check("rst_pready1", {31'h0, pready1}, 32'h0);
    presetn = 1'b1;
    @(posedge clk); #1;

    // penable without a SETUP phase must be ignored
    psel0 = 1'b1; psel1 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (pready0 || pready1) seen = 1'b1;
    end
    check("no_setup_pready", {31'h0, seen}, 32'h0);
    bus_idle();

    for (int i = 0; i < 16; i++) do_op(0, 1'b1, 8'(i * 4), $urandom, 4'hF, rd);
    for (int i = 0; i < 32; i++) do_op(1, 1'b1, 8'(i), $urandom, 4'hF, rd);
    bus_idle();

    do_op(1, 1'b1, 8'h10, 32'hA5, 4'h1, rd);
    do_op(1, 1'b0, 8'h10, 32'h0, 4'h0, rd);
    check("dir_a5", rd, 32'hA5);
    bus_idle();

    do_op(0, 1'b1, 8'h08, 32'h11223344, 4'hF, rd);
    do_op(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'b0101, rd);
    do_op(0, 1'b0, 8'h08, 32'h0, 4'h0, rd);
    check("dir_strb_merge", rd, 32'h11FF33FF);
    bus_idle();

    do_op(1, 1'b1, 8'h20, 32'h55, 4'h1, rd);
    do_op(1, 1'b0, 8'h20, 32'h0, 4'h0, rd);
    do_op(1, 1'b0, 8'h00, 32'h0, 4'h0, rd);
    bus_idle();

    do_op(0, 1'b1, 8'h04, 32'hCAFEF00D, 4'hF, rd);
    do_op(0, 1'b0, 8'h04, 32'h0, 4'h0, rd);
    check("b2b_read", rd, 32'hCAFEF00D);
    do_op(0, 1'b1, 8'h0C, 32'h0BADBEEF, 4'hF, rd);
    bus_idle();

    // reset in the middle of a waited write drops it
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = {24'h0, ~m1[5]}; pstrb = 4'h1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    presetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_pready", {31'h0, pready1}, 32'h0);
    check("midrst_pslverr", {31'h0, pslverr1}, 32'h0);
    check("midrst_prdata", {24'h0, prdata1}, 32'h0);
    presetn = 1'b1;
    bus_idle();
    do_op(1, 1'b0, 8'h05, 32'h0, 4'h0, rd);
    bus_idle();

    // master abort during ACCESS leaves memory untouched
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h06; pwdata = {24'h0, ~m1[6]}; pstrb = 4'h1;
    @(posedge clk); #1;
    bus_idle();
    do_op(1, 1'b0, 8'h06, 32'h0, 4'h0, rd);
    bus_idle();

    for (int i = 0; i < 300; i++) begin
      w = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = 8'((w == 0) ? $urandom_range(0, 63) : $urandom_range(0, 31));
      else a = 8'($urandom_range(0, 255));
      do_op(w, 1'($urandom), a, $urandom, 4'($urandom), rd);
      if ($urandom_range(0, 1) == 1) bus_idle();
    end
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
